// File: rtl/max1452_pkg.sv
// Shared types and constants for the MAX1452 configuration path.
package max1452_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_GAP
  } tx_state_t;

  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

  // Command opcodes issued by the upstream configuration sequencer
  localparam logic [7:0] OP_WRITE_EEPROM_PAGE = 8'h09;
  localparam logic [7:0] OP_TERMINATOR        = 8'hFA;

endpackage

// File: rtl/max1452_byte_fifo.sv
// Small synchronous byte FIFO with a registered occupancy count.
module max1452_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("max1452_byte_fifo: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Full/empty come from the registered count only, so a same-cycle pop never frees a slot early
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/max1452_uart_tx.sv
// 8N1 serialiser for the MAX1452 UART pin: byte FIFO, baud divider and inter-frame idle gap.
module max1452_uart_tx
  import max1452_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic [7:0] sent_cnt,
  output logic       rs_tx
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_MAX  = (GAP_BITS > DATA_BITS) ? GAP_BITS : DATA_BITS;
  localparam int IW       = $clog2(IDX_MAX + 1);

  generate
    if (BAUD_DIV < 4) begin : g_bad_div
      $error("max1452_uart_tx: CLK_HZ/BAUD must be >= 4");
    end
  endgenerate

  tx_state_t     r_state;
  logic [BW-1:0] r_baud;
  logic [IW-1:0] r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_sent_cnt;
  logic          r_tx;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_fifo_data;
  logic          w_bit_end;
  logic          w_line;

  assign w_push    = tx_valid && !w_full;
  assign w_pop     = (r_state == TX_IDLE) && !w_empty;
  assign w_bit_end = (r_baud == BW'(BAUD_DIV - 1));

  max1452_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (tx_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      TX_START: w_line = 1'b0;
      TX_DATA:  w_line = r_shift[0];
      default:  w_line = 1'b1;
    endcase
  end

  // The line register follows the state one cycle later, so every bit lasts exactly BAUD_DIV cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= TX_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_sent_cnt <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx <= w_line;
      if (r_state != TX_IDLE) r_baud <= w_bit_end ? '0 : r_baud + BW'(1);
      case (r_state)
        TX_IDLE: begin
          if (!w_empty) begin
            r_shift   <= w_fifo_data;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= TX_START;
          end
        end
        TX_START: begin
          if (w_bit_end) r_state <= TX_DATA;
        end
        TX_DATA: begin
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == IW'(DATA_BITS - 1)) begin
              r_bit_idx <= '0;
              r_state   <= TX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + IW'(1);
            end
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            r_sent_cnt <= r_sent_cnt + 8'd1;
            r_bit_idx  <= '0;
            r_state    <= (GAP_BITS > 0) ? TX_GAP : TX_IDLE;
          end
        end
        TX_GAP: begin
          if (w_bit_end) begin
            if (int'(r_bit_idx) == GAP_BITS - 1) r_state <= TX_IDLE;
            else r_bit_idx <= r_bit_idx + IW'(1);
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign tx_ready = !w_full;
  assign tx_busy  = !w_empty || (r_state != TX_IDLE);
  assign sent_cnt = r_sent_cnt;
  assign rs_tx    = r_tx;

endmodule

// File: tb/tb_max1452_uart_tx.sv
// Scoreboard bench for max1452_uart_tx: a line-decoding monitor checks every frame against queued bytes.
module tb_max1452_uart_tx;
  import max1452_pkg::*;

  localparam int BAUD_TB = 9600;
  localparam int DIV_A   = 16;
  localparam int GAP_A   = 1;
  localparam int DIV_B   = 8;
  localparam int GAP_B   = 0;
  localparam int PER_A   = (10 + GAP_A) * DIV_A + 1;
  localparam int PER_B   = (10 + GAP_B) * DIV_B + 1;

  logic       clk;
  logic       rstA_n, rstB_n;
  logic [7:0] dataA, dataB;
  logic       validA, validB;
  logic       readyA, readyB;
  logic       busyA, busyB;
  logic [7:0] sentA, sentB;
  logic       rsTxA, rsTxB;

  int         cyc;
  int         nVec;
  int         nMis;
  bit         monEnA;
  bit         monEnB;
  logic [7:0] expQA[$];
  logic [7:0] expQB[$];
  int         startsA[$];
  int         startsB[$];

  max1452_uart_tx #(
    .CLK_HZ(DIV_A * BAUD_TB), .BAUD(BAUD_TB), .FIFO_DEPTH(4), .GAP_BITS(GAP_A)
  ) dutA (
    .clk(clk), .rst_n(rstA_n), .tx_data(dataA), .tx_valid(validA),
    .tx_ready(readyA), .tx_busy(busyA), .sent_cnt(sentA), .rs_tx(rsTxA)
  );

  max1452_uart_tx #(
    .CLK_HZ(DIV_B * BAUD_TB), .BAUD(BAUD_TB), .FIFO_DEPTH(4), .GAP_BITS(GAP_B)
  ) dutB (
    .clk(clk), .rst_n(rstB_n), .tx_data(dataB), .tx_valid(validB),
    .tx_ready(readyB), .tx_busy(busyB), .sent_cnt(sentB), .rs_tx(rsTxB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic lineOf(input int which);
    return (which == 0) ? rsTxA : rsTxB;
  endfunction

  // Decode frames off the wire, checking every bit for its full width, then compare with the scoreboard
  task automatic monitorLoop(input int which, input int div, input int gap);
    logic [7:0] got;
    logic [7:0] exp;
    int         startCyc;
    logic       badTiming;
    string      nmTiming;
    string      nmByte;
    nmTiming = (which == 0) ? "frame timing A" : "frame timing B";
    nmByte   = (which == 0) ? "frame byte A" : "frame byte B";
    forever begin
      @(negedge clk);
      if (((which == 0) ? monEnA : monEnB) && lineOf(which) === 1'b0) begin
        startCyc  = cyc;
        badTiming = 1'b0;
        got       = '0;
        for (int i = 1; i < div; i++) begin
          @(negedge clk);
          if (lineOf(which) !== 1'b0) badTiming = 1'b1;
        end
        for (int b = 0; b < 8; b++) begin
          for (int i = 0; i < div; i++) begin
            @(negedge clk);
            if (i == 0) got[b] = lineOf(which);
            else if (lineOf(which) !== got[b]) badTiming = 1'b1;
          end
        end
        for (int i = 0; i < div * (1 + gap); i++) begin
          @(negedge clk);
          if (lineOf(which) !== 1'b1) badTiming = 1'b1;
        end
        checkOutput(nmTiming, {31'd0, badTiming}, 32'd0);
        if (((which == 0) ? expQA.size() : expQB.size()) == 0) begin
          nVec++;
          nMis++;
          $display("[TB] FAIL %s: got unexpected frame %0h, expected no frame", nmByte, got);
        end else begin
          exp = (which == 0) ? expQA.pop_front() : expQB.pop_front();
          checkOutput(nmByte, {24'd0, got}, {24'd0, exp});
        end
        if (which == 0) startsA.push_back(startCyc);
        else startsB.push_back(startCyc);
      end
    end
  endtask

  initial monitorLoop(0, DIV_A, GAP_A);
  initial monitorLoop(1, DIV_B, GAP_B);

  // Offer one byte; it is recorded as expected only when the handshake completes
  task automatic applyStimulus(input int which, input logic [7:0] b, output int acc);
    int waited;
    waited = 0;
    acc    = -1;
    if (((which == 0) ? validA : validB) == 1'b0) begin
      @(posedge clk);
      #1;
    end
    if (which == 0) begin dataA = b; validA = 1'b1; end
    else begin dataB = b; validB = 1'b1; end
    forever begin
      @(negedge clk);
      if (((which == 0) ? readyA : readyB) === 1'b1) begin
        if (which == 0) expQA.push_back(b);
        else expQB.push_back(b);
        @(posedge clk);
        #1;
        acc = cyc;
        return;
      end
      @(posedge clk);
      #1;
      waited++;
      if (waited > 2000) begin
        nVec++;
        nMis++;
        $display("[TB] FAIL push handshake: tx_ready low for %0d cycles, required high", waited);
        return;
      end
    end
  endtask

  task automatic gotoNeg(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic waitIdle(input int which, input int maxCyc, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (((which == 0) ? busyA : busyB) !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > maxCyc) begin
        nVec++;
        nMis++;
        $display("[TB] FAIL %s: tx_busy high after %0d cycles, required low", name, maxCyc);
        return;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic applyReset(input int which, input bit doCheck);
    @(negedge clk);
    if (which == 0) rstA_n = 1'b0;
    else rstB_n = 1'b0;
    repeat (3) @(negedge clk);
    if (doCheck) begin
      checkOutput("reset rs_tx",    {31'd0, lineOf(which)}, 32'd1);
      checkOutput("reset tx_ready", {31'd0, (which == 0) ? readyA : readyB}, 32'd1);
      checkOutput("reset tx_busy",  {31'd0, (which == 0) ? busyA : busyB}, 32'd0);
      checkOutput("reset sent_cnt", {24'd0, (which == 0) ? sentA : sentB}, 32'd0);
    end
    if (which == 0) rstA_n = 1'b1;
    else rstB_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         k;
    int         acc[6];
    logic [7:0] burst[6];
    int         bad;
    int         lowSeen;
    int         busySeen;
    int         nRand;
    logic [7:0] b;

    cyc = 0; nVec = 0; nMis = 0;
    rstA_n = 1'b0; rstB_n = 1'b0;
    dataA = '0; dataB = '0; validA = 1'b0; validB = 1'b0;
    monEnA = 1'b1; monEnB = 1'b1;
    burst[0] = 8'hF0; burst[1] = 8'h11; burst[2] = 8'h42;
    burst[3] = 8'h13; burst[4] = 8'h06; burst[5] = 8'h3C;

    $display("[TB] single byte 0x01");
    applyReset(0, 1'b1);
    applyStimulus(0, 8'h01, k);
    validA = 1'b0;
    gotoNeg(k + 1);
    checkOutput("line high before start", {31'd0, rsTxA}, 32'd1);
    gotoNeg(k + 2);
    checkOutput("start bit latency", {31'd0, rsTxA}, 32'd0);
    gotoNeg(k + 160);
    checkOutput("sent_cnt before stop end", {24'd0, sentA}, 32'd0);
    gotoNeg(k + 161);
    checkOutput("sent_cnt after stop end", {24'd0, sentA}, 32'd1);
    gotoNeg(k + 176);
    checkOutput("tx_busy during gap", {31'd0, busyA}, 32'd1);
    gotoNeg(k + 177);
    checkOutput("tx_busy after gap", {31'd0, busyA}, 32'd0);
    waitIdle(0, 400, "single idle");
    checkOutput("single queue drained", expQA.size(), 32'd0);

    $display("[TB] burst with full FIFO");
    applyReset(0, 1'b0);
    startsA.delete();
    for (int i = 0; i < 6; i++) applyStimulus(0, burst[i], acc[i]);
    validA = 1'b0;
    for (int i = 0; i < 6; i++)
      checkOutput("burst accept offset", acc[i] - acc[0], (i < 5) ? i : PER_A + 2);
    waitIdle(0, 6 * PER_A + 200, "burst idle");
    checkOutput("burst sent_cnt", {24'd0, sentA}, 32'd6);
    checkOutput("burst frame count", startsA.size(), 32'd6);
    bad = 0;
    for (int i = 1; i < startsA.size(); i++)
      if (startsA[i] - startsA[i-1] != PER_A) bad++;
    checkOutput("burst frame spacing", bad, 32'd0);
    checkOutput("burst queue drained", expQA.size(), 32'd0);

    $display("[TB] reset during data bit 3");
    applyReset(0, 1'b0);
    monEnA = 1'b0;
    applyStimulus(0, 8'hA5, k);
    applyStimulus(0, 8'h5A, acc[0]);
    validA = 1'b0;
    gotoNeg(k + 68);
    checkOutput("line at bit3 of A5", {31'd0, rsTxA}, 32'd0);
    #2;
    rstA_n = 1'b0;
    #1;
    checkOutput("async reset rs_tx", {31'd0, rsTxA}, 32'd1);
    checkOutput("async reset tx_ready", {31'd0, readyA}, 32'd1);
    checkOutput("async reset tx_busy", {31'd0, busyA}, 32'd0);
    repeat (3) @(negedge clk);
    rstA_n = 1'b1;
    lowSeen = 0;
    busySeen = 0;
    repeat (300) begin
      @(negedge clk);
      if (rsTxA !== 1'b1) lowSeen++;
      if (busyA !== 1'b0) busySeen++;
    end
    checkOutput("no frame after reset", lowSeen, 32'd0);
    checkOutput("FIFO flushed by reset", busySeen, 32'd0);
    checkOutput("sent_cnt after reset", {24'd0, sentA}, 32'd0);
    expQA.delete();
    monEnA = 1'b1;

    $display("[TB] random bytes with random spacing");
    nRand = 10;
    for (int i = 0; i < nRand; i++) begin
      if (i == 0) b = OP_WRITE_EEPROM_PAGE;
      else if (i == nRand - 1) b = OP_TERMINATOR;
      else b = 8'($urandom_range(0, 255));
      applyStimulus(0, b, k);
      validA = 1'b0;
      repeat ($urandom_range(0, 250)) begin
        @(posedge clk);
        #1;
      end
    end
    waitIdle(0, nRand * PER_A + 3000, "random idle");
    checkOutput("random sent_cnt", {24'd0, sentA}, nRand);
    checkOutput("random queue drained", expQA.size(), 32'd0);

    $display("[TB] 257 zero bytes, no gap");
    applyReset(1, 1'b1);
    startsB.delete();
    for (int i = 0; i < 257; i++) applyStimulus(1, 8'h00, k);
    validB = 1'b0;
    waitIdle(1, 257 * PER_B + 500, "wrap idle");
    checkOutput("wrap sent_cnt", {24'd0, sentB}, 32'd1);
    checkOutput("wrap frame count", startsB.size(), 32'd257);
    bad = 0;
    for (int i = 1; i < startsB.size(); i++)
      if (startsB[i] - startsB[i-1] != PER_B) bad++;
    checkOutput("wrap frame spacing", bad, 32'd0);
    checkOutput("wrap queue drained", expQB.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
